// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared op and state encodings for the EX-stage multiply/divide unit
package ex_mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/ex_mdu_seq_core.sv
// rtl/ex_mdu_seq_core.sv - shared shift register, adder/subtractor and iteration counter
module ex_mdu_seq_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] load_hi,
    input  logic [XLEN-1:0] load_lo,
    input  logic [XLEN-1:0] load_m,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] quo,
    output logic            last
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] m;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   opa;
    logic [XLEN+1:0] addsub;
    logic [XLEN:0]   mul_next;

    // Divide shifts {acc,quo} left before the trial subtract; multiply adds then shifts right.
    always_comb begin
        opa      = is_div ? {acc, quo[XLEN-1]} : {1'b0, acc};
        addsub   = is_div ? ({1'b0, opa} - {2'b0, m}) : ({1'b0, opa} + {2'b0, m});
        mul_next = quo[0] ? addsub[XLEN:0] : opa;
    end

    assign last = (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            quo <= '0;
            m   <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= load_hi;
            quo <= load_lo;
            m   <= load_m;
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                if (!addsub[XLEN+1]) begin
                    acc <= addsub[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    acc <= opa[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b0};
                end
            end else begin
                acc <= mul_next[XLEN:1];
                quo <= {mul_next[0], quo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle multiply/divide unit owning HI/LO with start/stall handshake
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    input  logic            Flush,
    output logic            Stall,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);
    mdu_state_e state;
    md_op_e     op;
    logic accept, arith, signed_op, sa, sb, go_fast;
    logic is_div, neg_q, neg_r, div_zero;
    logic [XLEN-1:0]   mag_a, mag_b, core_hi, core_lo, q_fix, r_fix, hi_next, lo_next;
    logic [2*XLEN-1:0] fast_prod, prod_fix;
    logic core_last;

    assign op        = md_op_e'(Op);
    assign accept    = Start && !Busy && !Flush;
    assign Stall     = Start && Busy && !Flush;
    assign Result    = Op[0] ? LO : HI;
    assign arith     = !Op[2];
    assign signed_op = !Op[0];
    assign sa        = signed_op && Rdata1[XLEN-1];
    assign sb        = signed_op && Rdata2[XLEN-1];
    assign mag_a     = sa ? -Rdata1 : Rdata1;
    assign mag_b     = sb ? -Rdata2 : Rdata2;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign go_fast   = (FAST_MUL != 0) && !Op[1];

    // The fast path preloads the finished magnitude product so FIX treats both paths alike.
    ex_mdu_seq_core #(.XLEN(XLEN)) u_core (
        .clk     (CLK),
        .rst     (RST),
        .load    (accept && arith),
        .step    (state == ST_CALC),
        .is_div  (is_div),
        .load_hi (go_fast ? fast_prod[2*XLEN-1:XLEN] : '0),
        .load_lo (go_fast ? fast_prod[XLEN-1:0] : mag_a),
        .load_m  (mag_b),
        .acc     (core_hi),
        .quo     (core_lo),
        .last    (core_last)
    );

    always_comb begin
        prod_fix = {core_hi, core_lo};
        if (neg_q) prod_fix = -prod_fix;
        q_fix = neg_q ? -core_lo : core_lo;
        if (div_zero) q_fix = '1;
        r_fix   = neg_r ? -core_hi : core_hi;
        hi_next = is_div ? r_fix : prod_fix[2*XLEN-1:XLEN];
        lo_next = is_div ? q_fix : prod_fix[XLEN-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            HI       <= '0;
            LO       <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state <= ST_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (accept) begin
                        case (op)
                            MD_MTHI: HI <= Rdata1;
                            MD_MTLO: LO <= Rdata1;
                            MD_MFHI, MD_MFLO: ;
                            default: begin
                                is_div   <= Op[1];
                                neg_q    <= sa ^ sb;
                                neg_r    <= sa;
                                div_zero <= (Rdata2 == '0);
                                Busy     <= 1'b1;
                                state    <= go_fast ? ST_FIX : ST_CALC;
                            end
                        endcase
                    end
                    ST_CALC: if (core_last) state <= ST_FIX;
                    ST_FIX: begin
                        HI    <= hi_next;
                        LO    <= lo_next;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
